// File: rtl/mic_pkg.sv
// Shared definitions for the microphone sample FIFO: default geometry, op encoding, clog2 helper.
// Optional build macro used by mic_sample_fifo: MIC_FIFO_OVERWRITE_EN.
package mic_pkg;

   localparam int unsigned MIC_DATA_WIDTH = 18;
   localparam int unsigned MIC_ADDR_WIDTH = 6;

   // Packed as {pop, push} so the enum can be cast straight from the two accept strobes.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mic_fifo_ram.sv
// Simple dual-port sample storage: synchronous write, registered read (block-RAM inferable).
// Only the output register is reset/cleared; the array itself carries no reset.
module mic_fifo_ram
   import mic_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = MIC_ADDR_WIDTH,
   parameter int unsigned WIDTH      = MIC_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [WIDTH-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
      end else if (clear) begin
         rd_q <= '0;
      end else if (rd_en) begin
         rd_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/mic_sample_fifo.sv
// Self-managing synchronous FIFO for mic PCM samples: pointers, occupancy and status flags.
// Build macro MIC_FIFO_OVERWRITE_EN: push on full overwrites the oldest entry instead of dropping.
module mic_sample_fifo
   import mic_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = MIC_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = MIC_DATA_WIDTH,
   parameter int unsigned CHANNELS    = 1,
   parameter int unsigned AFULL_LEVEL = 48
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           wr_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
   output logic                           wr_ready,
   input  logic                           rd_req,
   output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
   output logic                           rd_valid,
   output logic [ADDR_WIDTH:0]            level,
   output logic                           empty,
   output logic                           full,
   output logic                           almost_full,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int unsigned W     = CHANNELS * DATA_WIDTH;
   localparam int unsigned PW    = ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [PW-1:0]         wr_ptr, rd_ptr, level_q;
   logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt, level_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  empty_q, full_q, afull_q, ovf_q, udf_q, rd_valid_q;
   logic                  push_req, pop_req, push_ok, pop_ok, drop_old;
   fifo_op_e              op;

   always_comb begin
      push_req = wr_valid && !clear;
      pop_req  = rd_req && !clear;
`ifdef MIC_FIFO_OVERWRITE_EN
      push_ok  = push_req;
      drop_old = push_req && full_q;
`else
      push_ok  = push_req && !full_q;
      drop_old = 1'b0;
`endif
      pop_ok   = pop_req && !empty_q;
      op       = fifo_op_e'({pop_ok, push_ok});

      // An overwrite retires the oldest entry, so a concurrent pop reads the one after it.
      rd_addr    = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(drop_old);
      rd_ptr_nxt = rd_ptr + PW'(pop_ok) + PW'(drop_old);
      wr_ptr_nxt = wr_ptr + PW'(push_ok);

      level_nxt = level_q;
      case (op)
         OP_PUSH: level_nxt = level_q + PW'(1);
         OP_POP:  level_nxt = level_q - PW'(1);
         default: level_nxt = level_q;
      endcase
      if (drop_old) begin
         level_nxt = level_nxt - PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         level_q    <= level_nxt;
         empty_q    <= (level_nxt == '0);
         full_q     <= (level_nxt == PW'(DEPTH));
         afull_q    <= (level_nxt >= PW'(AFULL_LEVEL));
         ovf_q      <= ovf_q | (push_req && full_q);
         udf_q      <= udf_q | (pop_req && empty_q);
         rd_valid_q <= pop_ok;
      end
   end

   mic_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIDTH      (W)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data (wr_data),
      .rd_en   (pop_ok),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef MIC_FIFO_OVERWRITE_EN
   assign wr_ready = 1'b1;
`else
   assign wr_ready = !full_q;
`endif

   assign rd_valid    = rd_valid_q;
   assign level       = level_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_mic_sample_fifo.sv
// Randomised self-checking bench for mic_sample_fifo (2 channels) against a queue-based model.
// Honours MIC_FIFO_OVERWRITE_EN when the bundle is built with it.
module tb_mic_sample_fifo;
   import mic_pkg::*;

   localparam int unsigned AW    = 6;
   localparam int unsigned DW    = 18;
   localparam int unsigned CH    = 2;
   localparam int unsigned W     = CH * DW;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned AFULL = 48;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          wr_valid = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_ready;
   logic          rd_req = 1'b0;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic [AW:0]   level;
   logic          empty, full, almost_full, overflow, underflow;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] mq[$];
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;
   logic         m_rd_valid = 1'b0;
   logic [W-1:0] m_rd_data = '0;

   mic_sample_fifo #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .CHANNELS    (CH),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .rd_req      (rd_req),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .level       (level),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
   endtask

   task automatic model_step(input logic c, input logic wv, input logic [W-1:0] wd, input logic rr);
      bit           was_full, was_empty;
      logic [W-1:0] lost;
      if (c) begin
         model_reset();
      end else begin
         was_full   = (mq.size() == DEPTH);
         was_empty  = (mq.size() == 0);
         m_rd_valid = rr && !was_empty;
         if (rr && was_empty) m_udf = 1'b1;
`ifdef MIC_FIFO_OVERWRITE_EN
         if (wv && was_full) begin
            m_ovf = 1'b1;
            lost  = mq.pop_front();
         end
         if (m_rd_valid) m_rd_data = mq.pop_front();
         if (wv) mq.push_back(wd);
`else
         lost = '0;
         if (m_rd_valid) m_rd_data = mq.pop_front();
         if (wv) begin
            if (was_full) m_ovf = 1'b1;
            else mq.push_back(wd);
         end
`endif
      end
   endtask

   task automatic check_all();
      int unsigned sz;
      sz = mq.size();
      check_eq("level", 64'(level), 64'(sz));
      check_eq("empty", 64'(empty), 64'(sz == 0));
      check_eq("full", 64'(full), 64'(sz == DEPTH));
      check_eq("almost_full", 64'(almost_full), 64'(sz >= AFULL));
`ifdef MIC_FIFO_OVERWRITE_EN
      check_eq("wr_ready", 64'(wr_ready), 64'(1));
`else
      check_eq("wr_ready", 64'(wr_ready), 64'(sz != DEPTH));
`endif
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("underflow", 64'(underflow), 64'(m_udf));
      check_eq("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      check_eq("rd_data", 64'(rd_data), 64'(m_rd_data));
   endtask

   // Called at a falling edge; applies one cycle of stimulus and checks the post-edge state.
   task automatic cycle(input logic c, input logic wv, input logic [W-1:0] wd, input logic rr);
      clear    = c;
      wr_valid = wv;
      wr_data  = wd;
      rd_req   = rr;
      @(posedge clk);
      model_step(c, wv, wd, rr);
      @(negedge clk);
      check_all();
      clear    = 1'b0;
      wr_valid = 1'b0;
      rd_req   = 1'b0;
   endtask

   task automatic rand_word(output logic [W-1:0] w);
      w = {DW'($urandom), DW'($urandom)};
   endtask

   initial begin
      logic [W-1:0] d;
      int unsigned  pw, pr;

      // Reset state
      @(negedge clk);
      model_reset();
      check_all();
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) begin
         rand_word(d);
         cycle(1'b0, 1'b1, d, 1'b0);
      end
      cycle(1'b0, 1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_rst_level", 64'(level), 64'(0));
      check_eq("async_rst_empty", 64'(empty), 64'(1));
      check_eq("async_rst_rd_valid", 64'(rd_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      // Fill 0..63 then drain in order
      for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, W'(i), 1'b0);
      for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, '0, 1'b1);

      // Push onto a full FIFO, then drain
      for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, W'(i), 1'b0);
`ifdef MIC_FIFO_OVERWRITE_EN
      cycle(1'b0, 1'b1, W'(100), 1'b0);
`else
      cycle(1'b0, 1'b1, W'(36'hAAAA), 1'b0);
`endif
      cycle(1'b0, 1'b1, W'(36'h5555), 1'b1);
      for (int i = 0; i < 66; i++) cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b0);

      // Concurrent push+pop at level 10, then pop on empty
      for (int i = 0; i < 10; i++) begin
         rand_word(d);
         cycle(1'b0, 1'b1, d, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         rand_word(d);
         cycle(1'b0, 1'b1, d, 1'b1);
      end
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b1, W'(7), 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);

      // Two-channel packing, then clear mid-stream
      cycle(1'b0, 1'b1, {18'h2, 18'h1}, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1);
      check_eq("ch0", 64'(rd_data[17:0]), 64'(1));
      check_eq("ch1", 64'(rd_data[35:18]), 64'(2));
      for (int i = 0; i < 7; i++) begin
         rand_word(d);
         cycle(1'b0, 1'b1, d, (i % 3) == 0);
      end
      cycle(1'b1, 1'b1, W'(9), 1'b1);
      cycle(1'b0, 1'b1, W'(36'h3_0000_0001), 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1);

      // Random traffic: push-heavy phase, then pop-heavy phase, occasional clear
      for (int i = 0; i < 1200; i++) begin
         pw = (i < 600) ? 75 : 35;
         pr = (i < 600) ? 35 : 75;
         rand_word(d);
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pw, d,
               $urandom_range(0, 99) < pr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
